// File: rtl/shift_unit_iter.sv
// shift_unit_iter: multi-cycle SLL/SRL/SRA (and optional ROL) shifter that
// applies up to STEP positions per clock, with valid/ready on both sides.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-low reset
//   in_valid_i   request valid       in_ready_o   unit can accept a request
//   data_i       operand             shamt_i      shift amount (0..WIDTH-1)
//   op_i         00 SLL, 01 SRL, 10 SRA, 11 ROL (SLL when rotate disabled)
//   abort_i      synchronous cancel of the operation in flight
//   out_valid_o  result valid        out_ready_i  consumer accepts result
//   data_o       registered result   busy_o       high in SHIFT or DONE
//
// Build option: define SHIFT_ROTATE_EN to make op 11 rotate-left; otherwise
// op 11 decodes as SLL and no wrap-around logic is built.

module shift_unit_iter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned STEP    = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [1:0]         op_i,
    input  logic               abort_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   data_o,
    output logic               busy_o
);

    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SHIFT_ROTATE_EN
    localparam logic [1:0] OP_ROL = 2'b11;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [1:0]         op_q, op_d;
    logic               sign_q, sign_d;

    logic [SHAMT_W-1:0] amt_c;
    logic [WIDTH-1:0]   shifted_c;

    // Per-cycle shift step: min(rem, STEP) applied to the accumulator.
    always_comb begin
        amt_c     = (32'(rem_q) < STEP) ? rem_q : SHAMT_W'(STEP);
        shifted_c = acc_q << amt_c;
        case (op_q)
            OP_SRL: shifted_c = acc_q >> amt_c;
            // Vacated MSBs are exactly the bits cleared in ones >> amt.
            OP_SRA: shifted_c = (acc_q >> amt_c)
                              | (sign_q ? ~({WIDTH{1'b1}} >> amt_c) : '0);
`ifdef SHIFT_ROTATE_EN
            // amt is never 0 while shifting; a shift by WIDTH yields 0 anyway.
            OP_ROL: shifted_c = (acc_q << amt_c) | (acc_q >> (WIDTH - 32'(amt_c)));
`endif
            default: ;
        endcase
    end

    // Next-state and datapath-register logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        op_d    = op_q;
        sign_d  = sign_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    acc_d   = data_i;
                    rem_d   = shamt_i;
                    op_d    = op_i;
                    sign_d  = data_i[WIDTH-1];
                    state_d = (shamt_i == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = shifted_c;
                    rem_d = rem_q - amt_c;
                    if (rem_q == amt_c) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (abort_i || (out_valid_o && out_ready_i)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
        end
    end

    // Registered outputs; the result is published one cycle after DONE is entered.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            in_ready_o  <= 1'b1;
            busy_o      <= 1'b0;
            out_valid_o <= 1'b0;
            data_o      <= '0;
        end else begin
            in_ready_o  <= (state_d == S_IDLE);
            busy_o      <= (state_d != S_IDLE);
            out_valid_o <= (state_q == S_DONE) && (state_d == S_DONE);
            if ((state_q == S_DONE) && (state_d == S_DONE) && !out_valid_o) begin
                data_o <= acc_q;
            end
        end
    end

endmodule
